rr_req_grant_arbiter: RTL and testbench

- Round-robin arbiter that shares one clocked resource between N requesters using a level req/gnt handshake.
- Sits in front of the shared datapath. Drives its one-hot grant vector, owner index and busy flag.
- A hold watchdog forces release when an owner holds the grant too long.
- Sized so a two-requester instance (signals a, b) maps directly onto the codebase's assertion benches.

---
 rtl/rr_req_grant_arbiter.sv | 138 +++++++++++++
 tb/tb_rr_req_grant_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rr_req_grant_arbiter.sv
// Round-robin req/gnt arbiter with a hold watchdog for one shared clocked resource.
// Optional embedded assertions and covers are enabled by defining RR_ARB_ASSERT_EN.
module rr_req_grant_arbiter #(
   parameter int unsigned N        = 2,
   parameter int unsigned MAX_HOLD = 8,
   localparam int unsigned IDW     = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] owner,
   output logic           busy,
   output logic           timeout
);

   localparam int unsigned HW = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   gnt_d;
   logic [IDW-1:0] owner_d;
   logic           busy_d;
   logic           timeout_d;
   logic [HW-1:0]  hold_q, hold_d;
   logic [IDW-1:0] last_q, last_d;

   logic           found;
   logic [IDW-1:0] winner;

   // First requester after the last winner, wrapping modulo N.
   always_comb begin
      int unsigned    idx;
      logic [IDW-1:0] sel;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      sel    = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         idx = int'(last_q) + i;
         if (idx >= N) idx = idx - N;
         sel = IDW'(idx);
         if (!found && req[sel]) begin
            found  = 1'b1;
            winner = sel;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt     <= '0;
         owner   <= '0;
         busy    <= 1'b0;
         timeout <= 1'b0;
         hold_q  <= '0;
         last_q  <= IDW'(N - 1);
      end else begin
         state_q <= state_d;
         gnt     <= gnt_d;
         owner   <= owner_d;
         busy    <= busy_d;
         timeout <= timeout_d;
         hold_q  <= hold_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt;
      owner_d   = owner;
      busy_d    = busy;
      timeout_d = 1'b0;
      hold_d    = hold_q;
      last_d    = last_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d   = N'(1) << winner;
               owner_d = winner;
               busy_d  = 1'b1;
               last_d  = winner;
               hold_d  = HW'(1);
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (!req[owner]) begin
               gnt_d   = '0;
               busy_d  = 1'b0;
               hold_d  = '0;
               state_d = RELEASE;
            end else if (hold_q == HW'(MAX_HOLD)) begin
               gnt_d     = '0;
               busy_d    = 1'b0;
               hold_d    = '0;
               timeout_d = 1'b1;
               state_d   = RELEASE;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         RELEASE: state_d = IDLE;
         default: begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            hold_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

`ifdef RR_ARB_ASSERT_EN
   logic [N-1:0] prev_gnt;

   // Most recent non-zero grant, used to spot an ownership change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    prev_gnt <= '0;
      else if (busy) prev_gnt <= gnt;
   end

   a_onehot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
   a_busy:    assert property (@(posedge clk) disable iff (!rst_n) busy == (|gnt));
   a_owner:   assert property (@(posedge clk) disable iff (!rst_n) busy |-> gnt[owner]);
   a_gap:     assert property (@(posedge clk) disable iff (!rst_n) $fell(busy) |=> (gnt == '0));
   a_hold:    assert property (@(posedge clk) disable iff (!rst_n) hold_q <= HW'(MAX_HOLD));
   a_timeout: assert property (@(posedge clk) disable iff (!rst_n) timeout |-> !busy);
   c_handoff: cover property (@(posedge clk) disable iff (!rst_n)
                              busy && (prev_gnt != '0) && (gnt != prev_gnt));
   c_timeout: cover property (@(posedge clk) disable iff (!rst_n) timeout);
`else
   // Assertions and covers compiled out.
`endif

endmodule

// File: tb/tb_rr_req_grant_arbiter.sv
// Scoreboard bench for rr_req_grant_arbiter (N=2, MAX_HOLD=4) driven by hand-computed vectors.
module tb_rr_req_grant_arbiter;

   typedef struct packed {
      int         idx;
      logic [1:0] req;
      logic [1:0] gnt;
      logic       owner;
      logic       busy;
      logic       to;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req;
   logic [1:0] gnt;
   logic       owner;
   logic       busy;
   logic       timeout;

   int   checks = 0;
   int   failures = 0;
   int   n_vec = 0;
   vec_t exp_q[$];

   rr_req_grant_arbiter #(.N(2), .MAX_HOLD(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .owner   (owner),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s vec=%0d actual=%0d expected=%0d", name, idx, act, exp);
      end
   endfunction

   // Apply req for one cycle; expected outputs are those after the following rising edge.
   task automatic step(input logic [1:0] r, input logic [1:0] g, input logic o,
                       input logic b, input logic t);
      vec_t v;
      @(negedge clk);
      req = r;
      v.idx = n_vec; v.req = r; v.gnt = g; v.owner = o; v.busy = b; v.to = t;
      exp_q.push_back(v);
      n_vec++;
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #2;
      end
      check("drain_left", n_vec, exp_q.size(), 0);
   endtask

   // Monitor: compare each cycle's outputs against the oldest expectation.
   initial begin
      vec_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("gnt", e.idx, int'(gnt), int'(e.gnt));
            check("busy", e.idx, int'(busy), int'(e.busy));
            check("timeout", e.idx, int'(timeout), int'(e.to));
            if (e.busy) check("owner", e.idx, int'(owner), int'(e.owner));
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      req   = 2'b00;
      #1;
      check("rst_gnt", -1, int'(gnt), 0);
      check("rst_busy", -1, int'(busy), 0);
      check("rst_owner", -1, int'(owner), 0);
      check("rst_timeout", -1, int'(timeout), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Contended start, owner 0 releases, owner 1 picks up after the 2-cycle gap.
      step(2'b00, 2'b00, 0, 0, 0);
      step(2'b11, 2'b01, 0, 1, 0);
      step(2'b11, 2'b01, 0, 1, 0);
      step(2'b11, 2'b01, 0, 1, 0);
      step(2'b10, 2'b00, 0, 0, 0);
      step(2'b10, 2'b00, 0, 0, 0);
      step(2'b10, 2'b10, 1, 1, 0);
      step(2'b00, 2'b00, 0, 0, 0);
      step(2'b00, 2'b00, 0, 0, 0);
      step(2'b00, 2'b00, 0, 0, 0);

      // Single requester held: 4 grant cycles, timeout, gap, re-grant.
      step(2'b01, 2'b01, 0, 1, 0);
      step(2'b01, 2'b01, 0, 1, 0);
      step(2'b01, 2'b01, 0, 1, 0);
      step(2'b01, 2'b01, 0, 1, 0);
      step(2'b01, 2'b00, 0, 0, 1);
      step(2'b01, 2'b00, 0, 0, 0);
      step(2'b01, 2'b01, 0, 1, 0);
      step(2'b01, 2'b01, 0, 1, 0);
      step(2'b01, 2'b01, 0, 1, 0);
      step(2'b01, 2'b01, 0, 1, 0);
      step(2'b01, 2'b00, 0, 0, 1);
      step(2'b01, 2'b00, 0, 0, 0);
      step(2'b00, 2'b00, 0, 0, 0);
      step(2'b00, 2'b00, 0, 0, 0);

      // Both held: alternating 4-cycle holds, each ending in a timeout.
      step(2'b11, 2'b10, 1, 1, 0);
      step(2'b11, 2'b10, 1, 1, 0);
      step(2'b11, 2'b10, 1, 1, 0);
      step(2'b11, 2'b10, 1, 1, 0);
      step(2'b11, 2'b00, 0, 0, 1);
      step(2'b11, 2'b00, 0, 0, 0);
      step(2'b11, 2'b01, 0, 1, 0);
      step(2'b11, 2'b01, 0, 1, 0);
      step(2'b11, 2'b01, 0, 1, 0);
      step(2'b11, 2'b01, 0, 1, 0);
      step(2'b11, 2'b00, 0, 0, 1);
      step(2'b11, 2'b00, 0, 0, 0);
      step(2'b11, 2'b10, 1, 1, 0);
      // Non-owner drops its request mid-grant: no effect.
      step(2'b10, 2'b10, 1, 1, 0);
      step(2'b10, 2'b10, 1, 1, 0);
      drain();

      // Asynchronous reset while owner 1 holds the grant.
      @(negedge clk);
      req   = 2'b00;
      rst_n = 1'b0;
      #1;
      check("midrst_gnt", -2, int'(gnt), 0);
      check("midrst_busy", -2, int'(busy), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Pointer returned to N-1, so requester 0 wins first.
      step(2'b11, 2'b01, 0, 1, 0);
      step(2'b00, 2'b00, 0, 0, 0);
      step(2'b00, 2'b00, 0, 0, 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
